writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 137 +++++++++++++
 tb/tb_writeback_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: buffers ALU and load results, arbitrates them onto the
// register-file write port, and keeps a per-GPR busy scoreboard.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif
`ifndef L2_REG_FILE_SIZE
`define L2_REG_FILE_SIZE 5
`endif

module writeback_unit #(
  parameter int unsigned num_regs    = `REG_FILE_SIZE,
  parameter int unsigned l2_num_regs = `L2_REG_FILE_SIZE
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_issue_valid,
  input  logic [l2_num_regs-1:0] i_issue_rd,
  input  logic                   i_alu_valid,
  output logic                   o_alu_ready,
  input  logic [l2_num_regs-1:0] i_alu_rd,
  input  logic [`WORD_SIZE-1:0]  i_alu_data,
  input  logic                   i_mem_valid,
  output logic                   o_mem_ready,
  input  logic [l2_num_regs-1:0] i_mem_rd,
  input  logic [`WORD_SIZE-1:0]  i_mem_data,
  output logic                   o_load_gpr,
  output logic [l2_num_regs-1:0] o_load_gpr_sel,
  output logic [`WORD_SIZE-1:0]  o_load_gpr_data,
  input  logic [l2_num_regs-1:0] i_read_gpr_A_sel,
  input  logic [l2_num_regs-1:0] i_read_gpr_B_sel,
  output logic                   o_busy_A,
  output logic                   o_busy_B
);

  localparam int unsigned word_w = `WORD_SIZE;

  typedef enum logic {
    grant_alu = 1'b0,
    grant_mem = 1'b1
  } grant_t;

  logic                   alu_full, mem_full;
  logic [l2_num_regs-1:0] alu_rd, mem_rd;
  logic [word_w-1:0]      alu_data, mem_data;
  grant_t                 last_grant;
  logic [num_regs-1:0]    busy, busy_next;

  logic grant_alu_c, grant_mem_c, alu_take_c, mem_take_c;

  // Round-robin only matters under contention; a lone full buffer always wins.
  always_comb begin
    grant_alu_c = alu_full & (~mem_full | (last_grant == grant_mem));
    grant_mem_c = mem_full & (~alu_full | (last_grant == grant_alu));
    o_alu_ready = i_rst_n & (~alu_full | grant_alu_c);
    o_mem_ready = i_rst_n & (~mem_full | grant_mem_c);
    alu_take_c  = i_alu_valid & o_alu_ready & (i_alu_rd != '0);
    mem_take_c  = i_mem_valid & o_mem_ready & (i_mem_rd != '0);
  end

  // Buffers, output registers and arbitration history.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      alu_full        <= 1'b0;
      mem_full        <= 1'b0;
      alu_rd          <= '0;
      mem_rd          <= '0;
      alu_data        <= '0;
      mem_data        <= '0;
      last_grant      <= grant_alu;
      o_load_gpr      <= 1'b0;
      o_load_gpr_sel  <= '0;
      o_load_gpr_data <= '0;
    end else begin
      if (alu_take_c) begin
        alu_full <= 1'b1;
        alu_rd   <= i_alu_rd;
        alu_data <= i_alu_data;
      end else if (grant_alu_c) begin
        alu_full <= 1'b0;
      end

      if (mem_take_c) begin
        mem_full <= 1'b1;
        mem_rd   <= i_mem_rd;
        mem_data <= i_mem_data;
      end else if (grant_mem_c) begin
        mem_full <= 1'b0;
      end

      // History records only contested grants so paired arrivals alternate.
      if (alu_full && mem_full) begin
        last_grant <= grant_mem_c ? grant_mem : grant_alu;
      end

      if (grant_alu_c) begin
        o_load_gpr      <= 1'b1;
        o_load_gpr_sel  <= alu_rd;
        o_load_gpr_data <= alu_data;
      end else if (grant_mem_c) begin
        o_load_gpr      <= 1'b1;
        o_load_gpr_sel  <= mem_rd;
        o_load_gpr_data <= mem_data;
      end else begin
        o_load_gpr      <= 1'b0;
      end
    end
  end

  // Scoreboard: clear on writeback, set on issue; set wins on collision.
  always_comb begin
    busy_next = busy;
    if (o_load_gpr) begin
      busy_next[o_load_gpr_sel] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != '0)) begin
      busy_next[i_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    o_busy_A = busy[i_read_gpr_A_sel];
    o_busy_B = busy[i_read_gpr_B_sel];
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: latency, arbitration, rd=0 drop,
// scoreboard set/clear collisions and mid-operation reset.
`timescale 1ns/1ps
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        load_gpr;
  logic [4:0]  load_gpr_sel;
  logic [31:0] load_gpr_data;
  logic [4:0]  sel_a, sel_b;
  logic        busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  writeback_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_issue_valid    (issue_valid),
    .i_issue_rd       (issue_rd),
    .i_alu_valid      (alu_valid),
    .o_alu_ready      (alu_ready),
    .i_alu_rd         (alu_rd),
    .i_alu_data       (alu_data),
    .i_mem_valid      (mem_valid),
    .o_mem_ready      (mem_ready),
    .i_mem_rd         (mem_rd),
    .i_mem_data       (mem_data),
    .o_load_gpr       (load_gpr),
    .o_load_gpr_sel   (load_gpr_sel),
    .o_load_gpr_data  (load_gpr_data),
    .i_read_gpr_A_sel (sel_a),
    .i_read_gpr_B_sel (sel_b),
    .o_busy_A         (busy_a),
    .o_busy_B         (busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs changed afterwards settle well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    sel_a = 5'd0; sel_b = 5'd0;
    step(); step();
    check("rst_load", 32'(load_gpr), 32'd0);
    check("rst_sel", 32'(load_gpr_sel), 32'd0);
    check("rst_data", load_gpr_data, 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    rst_n = 1'b1; #1;
    check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    check("post_rst_mem_ready", 32'(mem_ready), 32'd1);

    // Single ALU result latency.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check("lat_k_load", 32'(load_gpr), 32'd0);
    step();
    check("lat_load", 32'(load_gpr), 32'd1);
    check("lat_sel", 32'(load_gpr_sel), 32'd5);
    check("lat_data", load_gpr_data, 32'hDEADBEEF);
    step();
    check("lat_drop", 32'(load_gpr), 32'd0);
    check("lat_hold_sel", 32'(load_gpr_sel), 32'd5);
    check("lat_hold_data", load_gpr_data, 32'hDEADBEEF);

    // First contention: MEM wins, ALU next.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("arb1_alu_ready", 32'(alu_ready), 32'd0);
    check("arb1_mem_ready", 32'(mem_ready), 32'd1);
    step();
    check("arb1_first_sel", 32'(load_gpr_sel), 32'd4);
    check("arb1_first_data", load_gpr_data, 32'h22);
    step();
    check("arb1_second_load", 32'(load_gpr), 32'd1);
    check("arb1_second_sel", 32'(load_gpr_sel), 32'd3);
    check("arb1_second_data", load_gpr_data, 32'h11);

    // Second contention: ALU wins.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    check("arb2_first_sel", 32'(load_gpr_sel), 32'd3);
    check("arb2_first_data", load_gpr_data, 32'h33);
    step();
    check("arb2_second_sel", 32'(load_gpr_sel), 32'd4);
    check("arb2_second_data", load_gpr_data, 32'h44);
    step();
    check("arb2_idle", 32'(load_gpr), 32'd0);

    // Scoreboard set, then clear on writeback.
    issue_valid = 1'b1; issue_rd = 5'd7; sel_a = 5'd7; sel_b = 5'd0;
    step();
    issue_valid = 1'b0;
    check("sb_set", 32'(busy_a), 32'd1);
    check("sb_r0", 32'(busy_b), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
    step();
    mem_valid = 1'b0;
    step();
    check("sb_wb_load", 32'(load_gpr), 32'd1);
    check("sb_busy_before_clear", 32'(busy_a), 32'd1);
    step();
    check("sb_cleared", 32'(busy_a), 32'd0);

    // Issue colliding with the clearing edge keeps the bit set.
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h78;
    step();
    mem_valid = 1'b0;
    step();
    check("sb_col_load", 32'(load_gpr), 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    check("sb_col_busy", 32'(busy_a), 32'd1);
    check("sb_col_idle", 32'(load_gpr), 32'd0);

    // rd=0 transfers are accepted and dropped.
    sel_a = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    check("r0_ready_pre", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0; issue_valid = 1'b0;
    check("r0_ready_post", 32'(alu_ready), 32'd1);
    check("r0_busy", 32'(busy_a), 32'd0);
    step();
    check("r0_no_load1", 32'(load_gpr), 32'd0);
    step();
    check("r0_no_load2", 32'(load_gpr), 32'd0);
    check("r0_hold_data", load_gpr_data, 32'h78);

    // Sustained contention: alternation MEM/ALU, readies never both low.
    alu_rd = 5'd10; alu_data = 32'hAAAA;
    mem_rd = 5'd11; mem_data = 32'hBBBB;
    for (int c = 0; c <= 9; c++) begin
      logic [4:0] exp_sel;
      alu_valid = (c < 7);
      mem_valid = (c < 4);
      #1;
      case (c)
        2, 4, 6: exp_sel = 5'd11;
        default: exp_sel = 5'd10;
      endcase
      if (c < 7) check($sformatf("alt_ready_or_c%0d", c), 32'(alu_ready | mem_ready), 32'd1);
      check($sformatf("alt_load_c%0d", c), 32'(load_gpr), 32'((c >= 2) && (c <= 8)));
      if ((c >= 2) && (c <= 8)) check($sformatf("alt_sel_c%0d", c), 32'(load_gpr_sel), 32'(exp_sel));
      if (c == 1) check("alt_c1_alu_ready", 32'(alu_ready), 32'd0);
      if (c == 2) check("alt_c2_mem_ready", 32'(mem_ready), 32'd0);
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Reset with both buffers full and a busy register.
    issue_valid = 1'b1; issue_rd = 5'd9; sel_a = 5'd9; sel_b = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h1212;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'h1313;
    step();
    issue_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    check("mr_busy9_set", 32'(busy_a), 32'd1);
    check("mr_busy7_set", 32'(busy_b), 32'd1);
    rst_n = 1'b0; #1;
    check("mr_alu_ready_low", 32'(alu_ready), 32'd0);
    check("mr_mem_ready_low", 32'(mem_ready), 32'd0);
    step();
    rst_n = 1'b1; #1;
    check("mr_load", 32'(load_gpr), 32'd0);
    check("mr_sel", 32'(load_gpr_sel), 32'd0);
    check("mr_data", load_gpr_data, 32'd0);
    check("mr_busy9", 32'(busy_a), 32'd0);
    check("mr_busy7", 32'(busy_b), 32'd0);
    check("mr_alu_ready", 32'(alu_ready), 32'd1);
    check("mr_mem_ready", 32'(mem_ready), 32'd1);
    step();
    check("mr_no_load1", 32'(load_gpr), 32'd0);
    step();
    check("mr_no_load2", 32'(load_gpr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
